// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the main-memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWrite,
      StRead,
      StDone
   } arb_state_e;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

   // Byte-offset bits inside one block of 32-bit words.
   function automatic int unsigned offset_bits(input int unsigned block_words);
      return $clog2(block_words) + 2;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals around the arbiter.
// master: the arbiter's view; slave: the caches/memory view.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  i_icache_req;
   logic [ADDR_WIDTH-1:0] i_icache_addr;
   logic [DATA_WIDTH-1:0] o_icache_rdata;
   logic                  o_icache_rvalid;
   logic                  o_icache_done;

   logic                  i_dcache_req;
   logic                  i_dcache_we;
   logic [ADDR_WIDTH-1:0] i_dcache_addr;
   logic [DATA_WIDTH-1:0] i_dcache_wdata;
   logic                  o_dcache_wready;
   logic [DATA_WIDTH-1:0] o_dcache_rdata;
   logic                  o_dcache_rvalid;
   logic                  o_dcache_done;

   logic                  o_mem_req;
   logic                  o_mem_we;
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic                  i_mem_ack;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic                  o_mem_wvalid;
   logic                  i_mem_wready;
   logic [DATA_WIDTH-1:0] i_mem_rdata;
   logic                  i_mem_rvalid;

   modport master (
      input  i_icache_req, i_icache_addr,
      output o_icache_rdata, o_icache_rvalid, o_icache_done,
      input  i_dcache_req, i_dcache_we, i_dcache_addr, i_dcache_wdata,
      output o_dcache_wready, o_dcache_rdata, o_dcache_rvalid, o_dcache_done,
      output o_mem_req, o_mem_we, o_mem_addr,
      input  i_mem_ack,
      output o_mem_wdata, o_mem_wvalid,
      input  i_mem_wready, i_mem_rdata, i_mem_rvalid
   );

   modport slave (
      output i_icache_req, i_icache_addr,
      input  o_icache_rdata, o_icache_rvalid, o_icache_done,
      output i_dcache_req, i_dcache_we, i_dcache_addr, i_dcache_wdata,
      input  o_dcache_wready, o_dcache_rdata, o_dcache_rvalid, o_dcache_done,
      input  o_mem_req, o_mem_we, o_mem_addr,
      output i_mem_ack,
      input  o_mem_wdata, o_mem_wvalid,
      output i_mem_wready, i_mem_rdata, i_mem_rvalid
   );

endinterface

// File: rtl/burst_counter.sv
// Beat counter for one block transfer; wraps to zero after the last beat.
module burst_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic i_clk,
   input  logic i_arst,
   input  logic i_clear,
   input  logic i_beat,
   output logic o_last
);

   logic [WIDTH-1:0] count_q;

   // Count accepted beats; natural wrap returns to zero after the block.
   always_ff @(posedge i_clk) begin
      if (i_arst || i_clear) begin
         count_q <= '0;
      end else if (i_beat) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign o_last = (count_q == {WIDTH{1'b1}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between I-cache refills and D-cache
// refills/writebacks. One requester is granted at a time (D has priority),
// a block-aligned burst is issued, BLOCK_WORDS beats move, then a one-cycle
// done pulse releases the requesting cache.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BLOCK_WORDS = 16
) (
   input logic                i_clk,
   input logic                i_arst,
   mem_port_arbiter_if.master bus
);

   localparam int unsigned CntWidth = $clog2(BLOCK_WORDS);
   localparam int unsigned OffBits  = offset_bits(BLOCK_WORDS);
   localparam logic [ADDR_WIDTH-1:0] AlignMask = {ADDR_WIDTH{1'b1}} << OffBits;

   arb_state_e            state_q;
   grant_e                grant_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;

   logic                  beat;
   logic                  last_beat;
   logic                  cnt_clear;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] wdata;

   assign mem_rdata = bus.i_mem_rdata;
   assign wdata     = bus.i_dcache_wdata;

   // A beat only counts in the data state matching the burst direction.
   always_comb begin
      beat = 1'b0;
      if (!i_arst) begin
         beat = ((state_q == StWrite) && bus.i_mem_wready) ||
                ((state_q == StRead) && bus.i_mem_rvalid);
      end
   end

   assign cnt_clear = (state_q == StReq);

   burst_counter #(
      .WIDTH (CntWidth)
   ) u_burst_counter (
      .i_clk   (i_clk),
      .i_arst  (i_arst),
      .i_clear (cnt_clear),
      .i_beat  (beat),
      .o_last  (last_beat)
   );

   // Transfer FSM: grant, hold the burst request until ack, move beats, done.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         state_q <= StIdle;
         grant_q <= GRANT_I;
         we_q    <= 1'b0;
         addr_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               // Data side first: it belongs to the older instruction.
               if (bus.i_dcache_req) begin
                  grant_q <= GRANT_D;
                  we_q    <= bus.i_dcache_we;
                  addr_q  <= bus.i_dcache_addr & AlignMask;
                  state_q <= StReq;
               end else if (bus.i_icache_req) begin
                  grant_q <= GRANT_I;
                  we_q    <= 1'b0;
                  addr_q  <= bus.i_icache_addr & AlignMask;
                  state_q <= StReq;
               end
            end
            StReq: begin
               if (bus.i_mem_ack) begin
                  state_q <= we_q ? StWrite : StRead;
               end
            end
            StWrite, StRead: begin
               if (beat && last_beat) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Outputs decode from registered state; data paths pass straight through.
   always_comb begin
      bus.o_icache_rdata  = '0;
      bus.o_icache_rvalid = 1'b0;
      bus.o_icache_done   = 1'b0;
      bus.o_dcache_wready = 1'b0;
      bus.o_dcache_rdata  = '0;
      bus.o_dcache_rvalid = 1'b0;
      bus.o_dcache_done   = 1'b0;
      bus.o_mem_req       = 1'b0;
      bus.o_mem_we        = 1'b0;
      bus.o_mem_addr      = '0;
      bus.o_mem_wdata     = '0;
      bus.o_mem_wvalid    = 1'b0;
      // Everything stays quiet while reset is held, even mid-burst.
      if (!i_arst) begin
         case (state_q)
            StReq: begin
               bus.o_mem_req  = 1'b1;
               bus.o_mem_we   = we_q;
               bus.o_mem_addr = addr_q;
            end
            StWrite: begin
               bus.o_mem_wvalid    = 1'b1;
               bus.o_mem_wdata     = wdata;
               bus.o_dcache_wready = bus.i_mem_wready;
            end
            StRead: begin
               if (grant_q == GRANT_D) begin
                  bus.o_dcache_rdata  = mem_rdata;
                  bus.o_dcache_rvalid = bus.i_mem_rvalid;
               end else begin
                  bus.o_icache_rdata  = mem_rdata;
                  bus.o_icache_rvalid = bus.i_mem_rvalid;
               end
            end
            StDone: begin
               if (grant_q == GRANT_D) begin
                  bus.o_dcache_done = 1'b1;
               end else begin
                  bus.o_icache_done = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single main-memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- The data side is raised when the pipeline flags a load or store memory access that misses.
- A multi-cycle FSM grants one requester at a time, issues a block-aligned burst request, and moves BLOCK_WORDS data beats.
- At the end it returns a one-cycle done pulse that releases the requesting cache's stall.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, width of one beat (one word).
- BLOCK_WORDS, 16, beats per cache block; power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  reset; synchronous, active-high.
- i_icache_req  in  1  I-cache refill request; held high until o_icache_done.
- i_icache_addr  in  ADDR_WIDTH  refill address; any byte in the block.
- o_icache_rdata  out  DATA_WIDTH  refill beat data.
- o_icache_rvalid  out  1  refill beat valid.
- o_icache_done  out  1  one-cycle pulse; block transfer complete.
- i_dcache_req  in  1  D-cache request; held high until o_dcache_done.
- i_dcache_we  in  1  1 = writeback of a dirty block, 0 = refill.
- i_dcache_addr  in  ADDR_WIDTH  block address.
- i_dcache_wdata  in  DATA_WIDTH  current writeback word.
- o_dcache_wready  out  1  current writeback word consumed; D-cache advances to next word.
- o_dcache_rdata  out  DATA_WIDTH  refill beat data.
- o_dcache_rvalid  out  1  refill beat valid.
- o_dcache_done  out  1  one-cycle pulse; transfer complete.
- o_mem_req  out  1  burst request valid.
- o_mem_we  out  1  burst direction (1 = write).
- o_mem_addr  out  ADDR_WIDTH  block-aligned burst address.
- i_mem_ack  in  1  memory accepted the burst request.
- o_mem_wdata  out  DATA_WIDTH  write beat data.
- o_mem_wvalid  out  1  write beat valid.
- i_mem_wready  in  1  memory accepts write beat.
- i_mem_rdata  in  DATA_WIDTH  read beat data.
- i_mem_rvalid  in  1  read beat valid.

Behaviour:
- States: IDLE, REQ, WRITE, READ, DONE.
- Reset: state IDLE, beat counter 0, grant register cleared. Every output is 0 while i_arst is high and in the first IDLE cycle after it.
- Reset mid-burst: abandon the transfer. No done pulse is issued. Memory-side recovery is the memory's responsibility, because both sides share the same reset.
- IDLE:
  - If i_dcache_req is high, latch grant = D, plus we and addr.
  - Else if i_icache_req is high, latch grant = I, addr, and we = 0.
  - Data has fixed priority because it is the older instruction. Both requests in the same cycle means D wins and I waits in IDLE.
  - Go to REQ on the next edge. Latency from req to o_mem_req is 1 cycle.
- REQ:
  - o_mem_req = 1; o_mem_we and o_mem_addr come from the latched values.
  - o_mem_addr has its low log2(BLOCK_WORDS)+2 bits cleared.
  - Hold all three stable until i_mem_ack. On ack, go to WRITE (we = 1) or READ (we = 0); counter = 0.
- WRITE:
  - o_mem_wvalid = 1 and o_mem_wdata = i_dcache_wdata (combinational pass-through).
  - o_dcache_wready = i_mem_wready.
  - Each cycle with wvalid & wready is one beat and increments the counter.
  - A beat when counter == BLOCK_WORDS-1 goes to DONE.
- READ:
  - The granted side's rdata = i_mem_rdata and rvalid = i_mem_rvalid, both combinational. The non-granted side's rvalid is 0 and its rdata is 0.
  - A beat is i_mem_rvalid; count as in WRITE; the last beat goes to DONE.
  - No backpressure toward memory: caches must accept a beat every cycle.
- DONE:
  - The granted side's done = 1 for exactly one cycle, then IDLE.
  - A requester must clear its req on the edge where it samples done high. A req still high in the next IDLE is treated as a new request.
- The counter is log2(BLOCK_WORDS) bits wide and wraps to 0 on the last beat.
- Memory-side stray signals are ignored: i_mem_rvalid in WRITE/IDLE/REQ/DONE, and i_mem_wready outside WRITE.
- The latched addr/we are not affected by changes on request inputs after the grant.
- Zero-wait handling:
  - i_mem_ack high in the first REQ cycle costs one REQ cycle.
  - A full-rate transfer totals 1 (IDLE) + 1 (REQ) + BLOCK_WORDS + 1 (DONE) cycles.

Decomposition:
- mem_arb_pkg:
  - typedef enum for the FSM states;
  - typedef enum {GRANT_I, GRANT_D} for the grant;
  - localparam function to derive the offset bit count from BLOCK_WORDS.
- One sub-module, burst_counter:
  - parameter WIDTH;
  - inputs i_clk, i_arst, i_clear, i_beat;
  - output o_last, asserted when count == 2**WIDTH-1.

Test Plan (bench uses BLOCK_WORDS=4):
- I refill alone, addr 0x0000_1234, ack on first REQ cycle, rdata 0xA0..0xA3 on consecutive cycles:
  - o_mem_addr = 0x0000_1230 and o_mem_we = 0;
  - o_icache_rvalid on 4 cycles with matching data;
  - o_icache_done one cycle after the 4th beat; o_dcache_* all 0.
- Simultaneous i_icache_req and i_dcache_req (refill, addr 0x2000):
  - D is granted first;
  - after o_dcache_done, the I request is granted with o_mem_req the cycle after the next IDLE.
- D writeback addr 0x3008, words 0x11..0x44, i_mem_wready toggling 1,0,1,0,1,0,1:
  - exactly 4 beats with o_mem_wdata 0x11, 0x22, 0x33, 0x44;
  - o_dcache_wready mirrors wready;
  - done after the 4th accepted beat.
- i_mem_ack withheld 5 cycles:
  - o_mem_req, o_mem_addr and o_mem_we stay stable for all 6 REQ cycles;
  - stray i_mem_rvalid pulses during REQ produce no rvalid and no count.
- Reset asserted after 2 read beats:
  - all outputs 0 the next cycle and no done issued;
  - a fresh I request then completes a full 4-beat transfer.
- Requester keeps req high one cycle past done:
  - a second identical transfer is granted; o_mem_req follows 1 cycle after IDLE.
